// File: rtl/sram_1rw1r_param.sv
// Single-clock SRAM with one read/write port and one read-only port.
// Provides byte write masks, a selectable read-during-write policy, a post-reset clear with ready, read strobes and a collision flag.
module sram_1rw1r_param #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 14,
  parameter int NUM_WMASKS     = DATA_WIDTH / 8,
  parameter int RDW_NEW        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ready,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  coll
);

  localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] r_dout0;
  logic [DATA_WIDTH-1:0] r_dout1;
  logic                  r_dout0_valid;
  logic                  r_dout1_valid;
  logic                  r_coll;

  logic                  w_run;
  logic                  w_wr0;
  logic                  w_rd0;
  logic                  w_rd1;
  logic                  w_coll;
  logic [DATA_WIDTH-1:0] w_rd1_data;

  assign w_run  = (r_state == ST_RUN);
  assign w_wr0  = w_run && !csb0 && !web0;
  assign w_rd0  = w_run && !csb0 && web0;
  assign w_rd1  = w_run && !csb1;
  assign w_coll = w_wr0 && w_rd1 && (addr0 == addr1);

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && r_clr_cnt == '1) begin
      w_state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_RUN);
      if (r_state == ST_INIT) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  // Port-1 data on a same-address write: old word, or old word with written lanes forwarded.
  always_comb begin
    w_rd1_data = r_mem[addr1];
    if (RDW_NEW != 0 && w_coll) begin
      for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) begin
          w_rd1_data[8*i +: 8] = din0[8*i +: 8];
        end
      end
    end
  end

  // Array is not reset; the clear sequencer owns it until RUN.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == ST_INIT) begin
        r_mem[r_clr_cnt] <= '0;
      end else if (w_wr0) begin
        for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
          if (wmask0[i]) begin
            r_mem[addr0][8*i +: 8] <= din0[8*i +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dout0       <= '0;
      r_dout1       <= '0;
      r_dout0_valid <= 1'b0;
      r_dout1_valid <= 1'b0;
      r_coll        <= 1'b0;
    end else begin
      r_dout0_valid <= w_rd0;
      r_dout1_valid <= w_rd1;
      r_coll        <= w_coll;
      if (w_rd0) begin
        r_dout0 <= r_mem[addr0];
      end
      if (w_rd1) begin
        r_dout1 <= w_rd1_data;
      end
    end
  end

  assign ready       = r_ready;
  assign dout0       = r_dout0;
  assign dout1       = r_dout1;
  assign dout0_valid = r_dout0_valid;
  assign dout1_valid = r_dout1_valid;
  assign coll        = r_coll;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench for sram_1rw1r_param: two instances (old-data/clear, new-data/no-clear) on shared stimulus,
// checked each cycle against a word-level memory model plus literal expectations.
module tb_sram_1rw1r_param;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, csb0, web0, csb1;
  logic [1:0]    wmask0;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0;

  logic [1:0]         rdy_w, v0_w, v1_w, coll_w;
  logic [1:0][DW-1:0] d0_w, d1_w;

  // Instance 0: RDW_NEW=0, CLEAR_ON_RESET=1.  Instance 1: RDW_NEW=1, CLEAR_ON_RESET=0.
  sram_1rw1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_NEW(0), .CLEAR_ON_RESET(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .ready(rdy_w[0]),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(d0_w[0]), .dout0_valid(v0_w[0]),
    .csb1(csb1), .addr1(addr1), .dout1(d1_w[0]), .dout1_valid(v1_w[0]), .coll(coll_w[0])
  );

  sram_1rw1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_NEW(1), .CLEAR_ON_RESET(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ready(rdy_w[1]),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(d0_w[1]), .dout0_valid(v0_w[1]),
    .csb1(csb1), .addr1(addr1), .dout1(d1_w[1]), .dout1_valid(v1_w[1]), .coll(coll_w[1])
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] lm(input logic [1:0] k);
    return {{8{k[1]}}, {8{k[0]}}};
  endfunction

  // Word-level model: per-lane "known" bits cover the uncleared array of instance 1.
  logic [DW-1:0] m_mem   [2][DEPTH];
  logic [1:0]    m_known [2][DEPTH];
  int            rel     [2];
  logic          e_rdy [2], e_v0 [2], e_v1 [2], e_coll [2];
  logic [DW-1:0] e_d0 [2], e_d1 [2];
  logic [1:0]    e_k0 [2], e_k1 [2];
  bit            m_init = 1'b0;

  task automatic model_step();
    bit srv, wr;
    if (!m_init) begin
      for (int c = 0; c < 2; c++) begin
        rel[c] = 0;
        for (int a = 0; a < DEPTH; a++) begin
          m_mem[c][a] = '0;
          m_known[c][a] = 2'b00;
        end
      end
      m_init = 1'b1;
    end
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        rel[c] = 0;
        e_rdy[c] = 0; e_v0[c] = 0; e_v1[c] = 0; e_coll[c] = 0;
        e_d0[c] = '0; e_d1[c] = '0; e_k0[c] = 2'b11; e_k1[c] = 2'b11;
      end else begin
        srv = (c == 0) ? (rel[c] >= DEPTH) : 1'b1;
        if (rel[c] < DEPTH) rel[c]++;
        if (c == 0 && rel[c] == DEPTH && !srv) begin
          for (int a = 0; a < DEPTH; a++) begin
            m_mem[c][a] = '0;
            m_known[c][a] = 2'b11;
          end
        end
        e_rdy[c] = (c == 0) ? (rel[c] >= DEPTH) : 1'b1;
        e_v0[c] = 0; e_v1[c] = 0; e_coll[c] = 0;
        if (srv) begin
          wr = !csb0 && !web0;
          if (!csb0 && web0) begin
            e_v0[c] = 1; e_d0[c] = m_mem[c][addr0]; e_k0[c] = m_known[c][addr0];
          end
          if (!csb1) begin
            e_v1[c] = 1; e_d1[c] = m_mem[c][addr1]; e_k1[c] = m_known[c][addr1];
          end
          if (wr && !csb1 && addr0 == addr1) begin
            e_coll[c] = 1;
            if (c == 1) begin
              for (int l = 0; l < 2; l++) begin
                if (wmask0[l]) begin
                  e_d1[c][8*l +: 8] = din0[8*l +: 8];
                  e_k1[c][l] = 1'b1;
                end
              end
            end
          end
          if (wr) begin
            for (int l = 0; l < 2; l++) begin
              if (wmask0[l]) begin
                m_mem[c][addr0][8*l +: 8] = din0[8*l +: 8];
                m_known[c][addr0][l] = 1'b1;
              end
            end
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("ready[%0d]", c), 32'(rdy_w[c]), 32'(e_rdy[c]));
        chk($sformatf("dout0_valid[%0d]", c), 32'(v0_w[c]), 32'(e_v0[c]));
        chk($sformatf("dout1_valid[%0d]", c), 32'(v1_w[c]), 32'(e_v1[c]));
        chk($sformatf("coll[%0d]", c), 32'(coll_w[c]), 32'(e_coll[c]));
        chk($sformatf("dout0[%0d]", c), 32'(d0_w[c] & lm(e_k0[c])), 32'(e_d0[c] & lm(e_k0[c])));
        chk($sformatf("dout1[%0d]", c), 32'(d1_w[c] & lm(e_k1[c])), 32'(e_d1[c] & lm(e_k1[c])));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready(output int na, output int nb, output int sawv);
    na = 0; nb = 0; sawv = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (rdy_w[1] && nb == 0) nb = i;
      if (v0_w[0]) sawv = 1;
      if (rdy_w[0]) begin
        na = i;
        break;
      end
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] m);
    csb0 = 0; web0 = 0; addr0 = a; din0 = d; wmask0 = m; csb1 = 1;
    step();
    csb0 = 1; web0 = 1;
  endtask

  int na, nb, sawv;
  logic [1:0][DW-1:0] last_d1;

  initial begin
    rst_n = 0; csb0 = 1; web0 = 1; csb1 = 1; wmask0 = '0; addr0 = '0; addr1 = '0; din0 = '0;
    step(); step();
    chk_en = 1'b1;
    step();
    chk("rst_ready", 32'(rdy_w), 32'h0);
    chk("rst_dout", 32'(d1_w), 32'h0);

    // Post-reset clear with a port-0 read pending throughout INIT
    csb0 = 0; web0 = 1; addr0 = 4'd9; rst_n = 1;
    wait_ready(na, nb, sawv);
    chk("clear_edges", 32'(na), 32'd16);
    chk("noclear_edges", 32'(nb), 32'd1);
    chk("init_no_valid", 32'(sawv), 32'd0);
    csb0 = 1;
    for (int a = 0; a < DEPTH; a++) begin
      csb1 = 0; addr1 = AW'(a);
      step();
      chk("clear_read", 32'(d1_w[0]), 32'h0);
    end
    csb1 = 1;

    // Byte masks
    wr(4'd3, 16'hABCD, 2'b11);
    wr(4'd3, 16'h1234, 2'b01);
    csb0 = 0; web0 = 1; addr0 = 4'd3;
    step();
    chk("mask_dout0_a", 32'(d0_w[0]), 32'hAB34);
    chk("mask_dout0_b", 32'(d0_w[1]), 32'hAB34);
    chk("mask_valid", 32'(v0_w), 32'h3);
    chk("model_mask", 32'(e_d0[0]), 32'hAB34);
    csb0 = 1;

    // Collisions
    wr(4'd5, 16'h1111, 2'b11);
    csb0 = 0; web0 = 0; addr0 = 4'd5; din0 = 16'h2222; wmask0 = 2'b11; csb1 = 0; addr1 = 4'd5;
    step();
    chk("coll_full", 32'(coll_w), 32'h3);
    chk("coll_old_a", 32'(d1_w[0]), 32'h1111);
    chk("coll_new_b", 32'(d1_w[1]), 32'h2222);
    csb0 = 1; web0 = 1;
    step();
    chk("after_coll_a", 32'(d1_w[0]), 32'h2222);
    wr(4'd5, 16'h1111, 2'b11);
    csb0 = 0; web0 = 0; addr0 = 4'd5; din0 = 16'h2222; wmask0 = 2'b10; csb1 = 0; addr1 = 4'd5;
    step();
    chk("coll_hi_old_a", 32'(d1_w[0]), 32'h1111);
    chk("coll_hi_new_b", 32'(d1_w[1]), 32'h2211);
    chk("model_rdw_new", 32'(e_d1[1]), 32'h2211);
    din0 = 16'h5555; wmask0 = 2'b00;
    step();
    chk("coll_nomask", 32'(coll_w), 32'h3);
    chk("coll_nomask_b", 32'(d1_w[1]), 32'h2211);
    csb0 = 1; web0 = 1;

    // Reset pulse during streaming reads
    wr(4'd7, 16'h00FF, 2'b11);
    csb1 = 0;
    for (int i = 0; i < 4; i++) begin
      addr1 = AW'(i);
      step();
    end
    rst_n = 0;
    step();
    chk("midrst_ready", 32'(rdy_w), 32'h0);
    chk("midrst_valid", 32'({v0_w, v1_w, coll_w}), 32'h0);
    chk("midrst_dout", 32'(d0_w) | 32'(d1_w), 32'h0);
    rst_n = 1;
    wait_ready(na, nb, sawv);
    chk("midrst_clear_edges", 32'(na), 32'd16);
    csb1 = 1; csb0 = 0; web0 = 1; addr0 = 4'd7;
    step();
    chk("midrst_rd_a", 32'(d0_w[0]), 32'h0000);
    chk("midrst_rd_b", 32'(d0_w[1]), 32'h00FF);

    // Back-to-back reads on both ports, then deselect port 1
    for (int i = 0; i < 100; i++) begin
      csb0 = 0; web0 = 1; addr0 = AW'($urandom);
      csb1 = 0; addr1 = (i % 2 == 0) ? AW'(i / 2) : AW'($urandom);
      step();
      chk("stream_valid1", 32'(v1_w), 32'h3);
    end
    last_d1 = d1_w;
    csb0 = 1; csb1 = 1;
    step();
    chk("desel_valid1", 32'(v1_w), 32'h0);
    chk("desel_hold1", 32'(d1_w), 32'(last_d1));
    step();
    chk("desel_hold1_2", 32'(d1_w), 32'(last_d1));

    // Random traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      rst_n  = ($urandom_range(0, 299) != 0);
      csb0   = ($urandom_range(0, 3) == 0);
      web0   = $urandom_range(0, 1) != 0;
      wmask0 = 2'($urandom);
      addr0  = AW'($urandom);
      din0   = DW'($urandom);
      csb1   = ($urandom_range(0, 4) == 0);
      addr1  = ($urandom_range(0, 1) != 0) ? addr0 : AW'($urandom);
      step();
    end
    rst_n = 1; csb0 = 1; csb1 = 1;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_1rw1r_param.md
# sram_1rw1r_param

Parametrised, synthesizable single-clock SRAM model with one read/write port (port 0) and one read-only port (port 1). It is the memory behind the pedal's delay/echo sample buffers and replaces the fixed-shape dual-clock model. It adds working byte write masks, a selectable read-during-write policy, a post-reset clear sequencer with a ready flag, per-port read-valid strobes and a collision flag.

## Interface
Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 14, address width; RAM_DEPTH = 1 << ADDR_WIDTH.
- NUM_WMASKS, DATA_WIDTH/8, byte-lane count; derived, never overridden.
- RDW_NEW, 0, port-1 read of an address port 0 writes on the same edge: 0 returns old data, 1 returns new merged data.
- CLEAR_ON_RESET, 1, 1 zero-fills the array after reset; 0 skips the fill.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ready  out  1  high once the array may be used.
- csb0  in  1  port 0 active-low chip select.
- web0  in  1  port 0 active-low write enable.
- wmask0  in  NUM_WMASKS  byte write enables; bit i covers din0[8i+7:8i].
- addr0  in  ADDR_WIDTH  port 0 address.
- din0  in  DATA_WIDTH  port 0 write data.
- dout0  out  DATA_WIDTH  port 0 read data, registered.
- dout0_valid  out  1  one-cycle strobe: dout0 was loaded on this edge.
- csb1  in  1  port 1 active-low chip select.
- addr1  in  ADDR_WIDTH  port 1 address.
- dout1  out  DATA_WIDTH  port 1 read data, registered.
- dout1_valid  out  1  one-cycle strobe: dout1 was loaded on this edge.
- coll  out  1  one-cycle strobe: port 0 wrote and port 1 read the same address on this edge.

## Operation
- Reset, on any edge with rst_n=0:
  - ready, dout0, dout1, dout0_valid, dout1_valid and coll all go to 0.
  - The FSM enters INIT (CLEAR_ON_RESET=1) or RUN (CLEAR_ON_RESET=0).
  - The clear counter goes to 0.
  - Array contents are untouched by reset itself.
- FSM states:
  - INIT: each edge writes all-zero to mem[clr_cnt] and increments clr_cnt. When clr_cnt = RAM_DEPTH-1, move to RUN and set ready=1 on that edge. Port requests in INIT are ignored, with no memory effect and no valid strobes.
  - RUN: ready=1 and requests are serviced. The FSM leaves RUN only by reset.
- Reset mid-INIT or mid-RUN restarts the sequence from clr_cnt=0. Any access sampled on a reset edge is dropped.
- Port 0 write (csb0=0, web0=0): for each i with wmask0[i]=1, mem[addr0] lane i = din0 lane i. Other lanes are kept. wmask0=0 is a legal no-op. dout0 holds its value and dout0_valid=0.
- Port 0 read (csb0=0, web0=1): dout0 = mem[addr0] and dout0_valid=1.
- Port 1 read (csb1=0): dout1 = mem[addr1] and dout1_valid=1.
- Deselected port: its dout holds its last value and its valid is 0.
- Same-address access: port-0 write and port-1 read at equal addresses on one edge assert coll=1.
  - RDW_NEW=0: dout1 = contents before the write.
  - RDW_NEW=1: dout1 = old word with the masked lanes replaced by din0.
  - coll is asserted even when wmask0=0; dout1 is then unchanged data either way.
- Addresses are used modulo RAM_DEPTH (full ADDR_WIDTH decode), so there is no out-of-range case.

## Timing
- Read latency is 1: inputs are sampled on edge k, and dout/valid are updated on edge k and stable during cycle k+1.
- A write on edge k is visible to a read sampled on edge k+1 on either port.
- Back-to-back accesses every cycle are allowed on both ports, with no bubbles.
- Clear duration: with CLEAR_ON_RESET=1, ready rises on the RAM_DEPTH-th rising edge with rst_n=1, counting the first such edge as 1. The first accepted request is on the following edge.
- With CLEAR_ON_RESET=0, ready rises on the first edge with rst_n=1.
- No combinational path from any input to any output.

## Test plan
- Reset/clear: DEPTH=16 (ADDR_WIDTH=4), CLEAR_ON_RESET=1. Release rst_n, then issue a port-0 read during INIT. Required: ready goes high after exactly 16 edges, the INIT read gives no dout0_valid, and port-1 reads of all 16 addresses return 0x0000.
- Byte masks: write 0xABCD to addr 3 with mask 2'b11, then 0x1234 with mask 2'b01, then read addr 3. Required: dout0=0xAB34 and dout0_valid=1 one edge after the read is sampled.
- Collision, RDW_NEW=0: mem[5]=0x1111. In one cycle, port 0 writes 0x2222 (mask 11) to addr 5 while port 1 reads addr 5. Required: coll=1 and dout1=0x1111. A port-1 read on the next cycle returns 0x2222.
- Collision, RDW_NEW=1: same stimulus with mask 2'b10. Required: coll=1 and dout1=0x2211.
- Mid-operation reset: write 0x00FF to addr 7, pulse rst_n low for 1 cycle during streaming reads. Required: all outputs are 0 during reset, and ready stays low for 16 edges after release. A read of addr 7 afterwards returns 0x0000 (CLEAR_ON_RESET=1) or 0x00FF (CLEAR_ON_RESET=0).
- Throughput/hold: continuous alternating reads on both ports for 100 cycles, then deassert csb1. Required: dout1_valid is high every cycle with the correct data; after deselect, dout1_valid=0 and dout1 keeps its last value.
